usb_ahb_master: RTL

AHB-Lite initiator that drives the USB endpoint's AHB slave register port (4-bit address, 32-bit data) from a simple command/response interface. It is the test/host-side counterpart of the endpoint slave and is used by the SoC sequencer and by system benches to move packet data and control and status values. It runs two-phase pipelined AHB transfers with wait-state and two-cycle ERROR handling. At most one address phase and one data phase are outstanding at a time.

---
 rtl/usb_ahb_master.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/usb_ahb_master.sv
// usb_ahb_master: AHB-Lite initiator for the USB endpoint register port.
//
// Converts a valid/ready command stream into pipelined two-phase AHB-Lite
// transfers. It keeps at most one address phase (stage p0) and one data phase
// (stage p1) in flight, and returns one in-order response pulse per command.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_*             command channel (cmd_valid/cmd_ready handshake)
//   rsp_*             response pulse (rsp_valid), read data, error flag
//   hsel..hwdata      registered AHB-Lite master outputs
//   hrdata/hresp/hready  AHB-Lite slave returns
//
// Optional feature (compile-time macro AHBM_ALIGN_CHECK_EN):
//   When defined, commands with size 3 or a misaligned address are rejected
//   locally. They take no bus cycle and answer with rsp_error = 1, in order.
module usb_ahb_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [1:0]        hsize,
  output logic              hwrite,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hresp,
  input  logic              hready
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Address-phase slot (p0). bus_p0 is high only for entries that really
  // occupy the bus, so a locally rejected entry never shows NONSEQ.
  logic              vld_p0;
  logic              bus_p0;
  logic              rej_p0;
  logic [DATA_W-1:0] wdata_p0;

  // Data-phase slot (p1).
  logic vld_p1;
  logic write_p1;
  logic rej_p1;

  // A command was dropped from p0 by an ERROR and still owes a response.
  logic cancel_pend;

  logic d_bus;
  logic err;
  logic err_wait;
  logic a_move;
  logic accept;
  logic rej_cmd;

`ifdef AHBM_ALIGN_CHECK_EN
  function automatic logic bad_align(input logic [1:0] size,
                                     input logic [ADDR_W-1:0] addr);
    logic bad;
    bad = 1'b0;
    case (size)
      2'd1:    bad = addr[0];
      2'd2:    bad = (addr[1:0] != 2'b00);
      2'd3:    bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  assign rej_cmd = bad_align(cmd_size, cmd_addr);
`else
  assign rej_cmd = 1'b0;
`endif

  always_comb begin
    // hresp only counts while a real data phase is on the bus.
    d_bus     = vld_p1 && !rej_p1;
    err       = d_bus && hresp;
    err_wait  = err && !hready;
    a_move    = vld_p0 && hready && !err;
    // Held off during any ERROR cycle and until a cancelled command retires.
    cmd_ready = !rst && !cancel_pend && !err && (!vld_p0 || hready);
    accept    = cmd_valid && cmd_ready;
  end

  assign hsel   = bus_p0;
  assign htrans = bus_p0 ? HTRANS_NONSEQ : HTRANS_IDLE;

  // ---- stage p0: address phase ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      bus_p0 <= 1'b0;
      rej_p0 <= 1'b0;
      haddr  <= '0;
      hsize  <= '0;
      hwrite <= 1'b0;
    end else if (accept) begin
      vld_p0 <= 1'b1;
      bus_p0 <= !rej_cmd;
      rej_p0 <= rej_cmd;
      haddr  <= cmd_addr;
      hsize  <= cmd_size;
      hwrite <= cmd_write;
    end else if (a_move || err_wait) begin
      // First ERROR cycle forces IDLE and drops the pending address phase.
      vld_p0 <= 1'b0;
      bus_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wdata_p0 <= cmd_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cancel_pend <= 1'b0;
    end else if (err_wait && vld_p0) begin
      cancel_pend <= 1'b1;
    end else if (cancel_pend && !vld_p1) begin
      cancel_pend <= 1'b0;
    end
  end

  // ---- stage p1: data phase ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      write_p1 <= 1'b0;
      rej_p1   <= 1'b0;
      hwdata   <= '0;
    end else if (hready) begin
      vld_p1 <= a_move;
      if (a_move) begin
        write_p1 <= hwrite;
        rej_p1   <= rej_p0;
        if (hwrite && !rej_p0) begin
          hwdata <= wdata_p0;
        end
      end
    end
  end

  // ---- stage p2: response ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (vld_p1 && hready) begin
        rsp_valid <= 1'b1;
        rsp_error <= rej_p1 || err;
        rsp_rdata <= (!write_p1 && !rej_p1 && !err) ? hrdata : '0;
      end else if (cancel_pend && !vld_p1) begin
        rsp_valid <= 1'b1;
        rsp_error <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule
